video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Pixel-clock-domain raster generator that sits directly upstream of the DVI TMDS encoders in `dvi_top`. It produces the hsync, vsync and data-enable (DE) control stream, plus pixel coordinates, for a parameterised CEA/VESA mode (default 640x480@60, 25.2 MHz pixel clock). Optionally it also produces a built-in colour-bar pixel stream. All outputs are registered and mutually aligned, so the encoders can consume them directly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- pixel_clk_i  in  1  pixel clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- hsync_o  out  1  horizontal sync at H_POL level
- vsync_o  out  1  vertical sync at V_POL level
- de_o  out  1  high in the active area only
- x_o  out  $clog2(H_TOTAL)  horizontal counter, 0..H_TOTAL-1
- y_o  out  $clog2(V_TOTAL)  vertical counter, 0..V_TOTAL-1
- line_start_o  out  1  one-cycle pulse when x_o==0
- frame_start_o  out  1  one-cycle pulse when x_o==0 and y_o==0
- rgb_o  out  24  pixel data {R[7:0],G[7:0],B[7:0]}

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- h_cnt increments every cycle and wraps at H_TOTAL-1 to 0.
- v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1 to 0.
- Horizontal regions by h_cnt: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch.
- Vertical regions by v_cnt follow the same ordering.
- hsync is active in the h sync region. vsync is active in the v sync region, for whole lines, changing only at h_cnt==0.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Counter arithmetic is unsigned. Compares are at full counter width; there is no saturation.
- Reset values of all outputs:
  - hsync_o = ~H_POL, vsync_o = ~V_POL (inactive levels)
  - de_o, x_o, y_o, line_start_o, frame_start_o = 0
  - rgb_o = 0
- rst_i dominates everything. Asserting it mid-frame forces counters to (0,0) and outputs to their reset values in the next cycle; there is no partial-frame completion.

## Timing
- Every output is registered from the counter state: output = f(h_cnt, v_cnt) one cycle later, with no skew between outputs.
- The first rising edge with rst_i low loads outputs for (0,0): de_o=1, line_start_o=1, frame_start_o=1.
- One frame = H_TOTAL*V_TOTAL cycles (default 420000). frame_start_o period is exactly this.
- rgb_o is zero whenever de_o is 0, in the same cycle.

## Configuration
- VIDEO_TPG_EN defined:
  - video_tpg is instantiated.
  - rgb_o carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in the order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - The last bar absorbs the remainder when H_ACTIVE is not a multiple of 8.
- VIDEO_TPG_EN undefined:
  - video_tpg is not instantiated and rgb_o is constant 0.
  - Downstream logic sources pixels using x_o/y_o/de_o.

## Structure
- Package video_pkg holds:
  - default 640x480@60 timing localparams
  - typedef rgb_t (packed struct r,g,b of 8 bits each)
  - the 8 colour-bar constants
- Sub-module video_tpg: combinational pattern lookup from h_cnt and the active flag. Its output is registered in video_timing_gen so it stays aligned with de_o.

## Test plan
- Reset: hold rst_i 5 cycles -> hsync_o=1, vsync_o=1, de_o=0, x_o=0, y_o=0, rgb_o=0 throughout.
- Line timing: after release, per line de_o high for exactly 640 consecutive cycles; hsync_o low for exactly 96 cycles starting at x_o=656; line_start_o period 800.
- Frame timing: frame_start_o period 420000; vsync_o low for exactly 1600 cycles starting at y_o=490, x_o=0; de_o never high for y_o>=480.
- Colour bars (VIDEO_TPG_EN):
  - y_o=0: x_o=0 -> FFFFFF, x_o=80 -> FFFF00, x_o=639 -> 000000.
  - x_o=700 -> rgb_o=0.
  - Without the macro, rgb_o=0 always.
- Mid-frame reset: assert rst_i one cycle at y_o=200, x_o=300 -> outputs at reset values next cycle; the following cycle x_o=0, y_o=0, frame_start_o=1.
- Small mode (H 8/2/2/2, V 4/1/1/1): wrap at x_o=13 -> 0 and y_o=6 -> 0; frame period 98 cycles.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the raster generator: default 640x480@60 timing,
// the pixel type, and the eight colour-bar values with their lookup.
// Used by video_timing_gen and video_tpg.
package video_pkg;

    // Default mode: 640x480@60, 25.2 MHz pixel clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_H_POL    = 1'b0;
    localparam bit DEF_V_POL    = 1'b0;

    // Number of vertical colour bars in the test pattern.
    localparam int NUM_BARS = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Colour bars, left to right.
    localparam rgb_t BAR_WHITE   = 24'hFF_FF_FF;
    localparam rgb_t BAR_YELLOW  = 24'hFF_FF_00;
    localparam rgb_t BAR_CYAN    = 24'h00_FF_FF;
    localparam rgb_t BAR_GREEN   = 24'h00_FF_00;
    localparam rgb_t BAR_MAGENTA = 24'hFF_00_FF;
    localparam rgb_t BAR_RED     = 24'hFF_00_00;
    localparam rgb_t BAR_BLUE    = 24'h00_00_FF;
    localparam rgb_t BAR_BLACK   = 24'h00_00_00;

    // Map a bar index (0 = leftmost) to its colour.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_tpg.sv
// Colour-bar pattern lookup: eight vertical bars of H_ACTIVE/8 pixels.
// Latency: combinational; the caller registers the result.
// No flow control; output is black outside the active area.
module video_tpg
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HW       = 10
) (
    input  logic [HW-1:0] h_cnt,
    input  logic          active,
    output rgb_t          rgb
);

    // Modes narrower than eight pixels still get one pixel per bar.
    localparam int BAR_W = (H_ACTIVE >= NUM_BARS) ? (H_ACTIVE / NUM_BARS) : 1;
    localparam logic [HW-1:0] BAR_W_L = HW'(BAR_W);
    localparam logic [HW-1:0] LAST_BAR = HW'(NUM_BARS - 1);

    logic [HW-1:0] bar_idx;
    logic [2:0]    bar_sel;

    // Pick the bar under h_cnt; the last bar swallows any remainder pixels.
    always_comb begin
        bar_idx = h_cnt / BAR_W_L;
        bar_sel = (bar_idx > LAST_BAR) ? 3'd7 : bar_idx[2:0];
        rgb     = '0;
        if (active) begin
            rgb = bar_colour(bar_sel);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates and line/frame
// pulses for a parameterised mode. All outputs registered one cycle after the
// counter state they describe. Optional colour bars when VIDEO_TPG_EN is defined.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = DEF_H_POL,
    parameter bit V_POL    = DEF_V_POL
) (
    input  logic                                                pixel_clk_i,
    input  logic                                                rst_i,
    output logic                                                hsync_o,
    output logic                                                vsync_o,
    output logic                                                de_o,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        x_o,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        y_o,
    output logic                                                line_start_o,
    output logic                                                frame_start_o,
    output logic [23:0]                                         rgb_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Region bounds carry one extra bit so an end bound equal to the total
    // (zero back porch) still fits.
    localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;

    logic h_active;
    logic v_active;
    logic h_in_sync;
    logic v_in_sync;
    logic de_nxt;
    logic line_nxt;
    logic frame_nxt;

    // Next raster position: h wraps every line, v advances on the h wrap.
    always_comb begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : (v_cnt + 1'b1);
        end
    end

    // Raster counters; reset restarts the frame at (0,0) with no completion.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Region decode of the current position, full-width unsigned compares.
    always_comb begin
        h_active  = {1'b0, h_cnt} <  H_ACT_END;
        v_active  = {1'b0, v_cnt} <  V_ACT_END;
        h_in_sync = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
        v_in_sync = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
        de_nxt    = h_active && v_active;
        line_nxt  = (h_cnt == '0);
        frame_nxt = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output register stage: every control output describes the same position.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            hsync_o       <= ~H_POL;
            vsync_o       <= ~V_POL;
            de_o          <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= h_in_sync ? H_POL : ~H_POL;
            vsync_o       <= v_in_sync ? V_POL : ~V_POL;
            de_o          <= de_nxt;
            x_o           <= h_cnt;
            y_o           <= v_cnt;
            line_start_o  <= line_nxt;
            frame_start_o <= frame_nxt;
        end
    end

`ifdef VIDEO_TPG_EN
    rgb_t tpg_rgb;

    video_tpg #(
        .H_ACTIVE (H_ACTIVE),
        .HW       (HW)
    ) u_tpg (
        .h_cnt  (h_cnt),
        .active (de_nxt),
        .rgb    (tpg_rgb)
    );

    // Pattern registered alongside de_o so black coincides with blanking.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            rgb_o <= '0;
        end else begin
            rgb_o <= tpg_rgb;
        end
    end
`else
    // No built-in pattern: downstream sources pixels from x_o/y_o/de_o.
    assign rgb_o = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default mode (line timing, bars), default-H with
// short vertical (frame timing, mid-frame reset) and the small 8/2/2/2 x 4/1/1/1
// mode with positive polarities. Expected outputs come from a position model.
module tb_video_timing_gen;

    localparam int MV_A = 12;
    localparam int MV_F = 2;
    localparam int MV_S = 2;
    localparam int MV_B = 3;
    localparam int HT_D = 800;
    localparam int FR_D = 800 * 525;
    localparam int FR_M = 800 * (MV_A + MV_F + MV_S + MV_B);
    localparam int FR_S = 14 * 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_m = 1'b1;
    logic rst_s = 1'b1;

    logic hs_d, vs_d, de_d, ls_d, fs_d;
    logic [9:0] x_d;
    logic [9:0] y_d;
    logic [23:0] rgb_d;

    logic hs_m, vs_m, de_m, ls_m, fs_m;
    logic [9:0] x_m;
    logic [4:0] y_m;
    logic [23:0] rgb_m;

    logic hs_s, vs_s, de_s, ls_s, fs_s;
    logic [3:0] x_s;
    logic [2:0] y_s;
    logic [23:0] rgb_s;

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_gen dut_d (
        .pixel_clk_i(clk), .rst_i(rst_d), .hsync_o(hs_d), .vsync_o(vs_d), .de_o(de_d),
        .x_o(x_d), .y_o(y_d), .line_start_o(ls_d), .frame_start_o(fs_d), .rgb_o(rgb_d)
    );

    video_timing_gen #(
        .V_ACTIVE(MV_A), .V_FP(MV_F), .V_SYNC(MV_S), .V_BP(MV_B)
    ) dut_m (
        .pixel_clk_i(clk), .rst_i(rst_m), .hsync_o(hs_m), .vsync_o(vs_m), .de_o(de_m),
        .x_o(x_m), .y_o(y_m), .line_start_o(ls_m), .frame_start_o(fs_m), .rgb_o(rgb_m)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_s (
        .pixel_clk_i(clk), .rst_i(rst_s), .hsync_o(hs_s), .vsync_o(vs_s), .de_o(de_s),
        .x_o(x_s), .y_o(y_s), .line_start_o(ls_s), .frame_start_o(fs_s), .rgb_o(rgb_s)
    );

    // Position model: number of non-reset edges since reset, modulo one frame.
    int pos_d = 0, pos_m = 0, pos_s = 0;
    bit inr_d = 1'b1, inr_m = 1'b1, inr_s = 1'b1;

    always @(posedge clk) begin
        if (rst_d) begin inr_d <= 1'b1; pos_d <= 0; end
        else begin pos_d <= inr_d ? 0 : (pos_d + 1) % FR_D; inr_d <= 1'b0; end
        if (rst_m) begin inr_m <= 1'b1; pos_m <= 0; end
        else begin pos_m <= inr_m ? 0 : (pos_m + 1) % FR_M; inr_m <= 1'b0; end
        if (rst_s) begin inr_s <= 1'b1; pos_s <= 0; end
        else begin pos_s <= inr_s ? 0 : (pos_s + 1) % FR_S; inr_s <= 1'b0; end
    end

    typedef struct {
        bit hs, vs, de, ls, fs;
        int x, y;
        logic [23:0] rgb;
    } exp_t;

    function automatic logic [23:0] bar_of(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic exp_t model(int p, bit in_rst, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, bit hp, bit vp);
        exp_t e;
        int ht, bw, idx;
        ht = ha + hf + hsw + hb;
        e.hs = ~hp; e.vs = ~vp; e.de = 0; e.ls = 0; e.fs = 0;
        e.x = 0; e.y = 0; e.rgb = 24'h0;
        if (!in_rst) begin
            e.x  = p % ht;
            e.y  = p / ht;
            e.de = (e.x < ha) && (e.y < va);
            e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : ~hp;
            e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : ~vp;
            e.ls = (e.x == 0);
            e.fs = (e.x == 0) && (e.y == 0);
`ifdef VIDEO_TPG_EN
            if (e.de) begin
                bw  = (ha >= 8) ? ha / 8 : 1;
                idx = e.x / bw;
                if (idx > 7) idx = 7;
                e.rgb = bar_of(idx);
            end
`endif
        end
        return e;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d, rgb_d} !== {5'b11000, 10'd0, 10'd0, 24'd0}) begin
                n_fail++;
                $display("FAIL reset_d cyc=%0d got=%h want=%h", i,
                         {hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d, rgb_d}, {5'b11000, 10'd0, 10'd0, 24'd0});
            end
            n_checks++;
            if ({hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m} !== {5'b11000, 10'd0, 5'd0, 24'd0}) begin
                n_fail++;
                $display("FAIL reset_m cyc=%0d got=%h", i, {hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m});
            end
            n_checks++;
            if ({hs_s, vs_s, de_s, ls_s, fs_s, x_s, y_s, rgb_s} !== {5'b00000, 4'd0, 3'd0, 24'd0}) begin
                n_fail++;
                $display("FAIL reset_s cyc=%0d got=%h", i, {hs_s, vs_s, de_s, ls_s, fs_s, x_s, y_s, rgb_s});
            end
        end
    endtask

    task automatic test_line_timing();
        exp_t e;
        logic [48:0] got, want;
        int de_run, hs_run, last_ls;
        bit prev_de, prev_hs;
        de_run = 0; hs_run = 0; last_ls = -1; prev_de = 0; prev_hs = 1;
        rst_d = 1'b0;
        for (int c = 0; c < 3 * HT_D; c++) begin
            @(negedge clk);
            e = model(pos_d, inr_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            got  = {hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d, rgb_d};
            want = {e.hs, e.vs, e.de, e.ls, e.fs, 10'(e.x), 10'(e.y), e.rgb};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL line_vec cyc=%0d got=%h want=%h", c, got, want);
            end
            if (de_d) de_run++;
            if (prev_de && !de_d) begin
                n_checks++;
                if (de_run != 640) begin n_fail++; $display("FAIL de_len got=%0d want=640", de_run); end
                de_run = 0;
            end
            if (prev_hs && !hs_d) begin
                n_checks++;
                if (x_d !== 10'd656) begin n_fail++; $display("FAIL hs_start got=%0d want=656", x_d); end
                hs_run = 0;
            end
            if (!hs_d) hs_run++;
            if (!prev_hs && hs_d) begin
                n_checks++;
                if (hs_run != 96) begin n_fail++; $display("FAIL hs_len got=%0d want=96", hs_run); end
            end
            if (ls_d) begin
                if (last_ls >= 0) begin
                    n_checks++;
                    if (c - last_ls != HT_D) begin
                        n_fail++; $display("FAIL ls_period got=%0d want=800", c - last_ls);
                    end
                end
                last_ls = c;
            end
            prev_de = de_d; prev_hs = hs_d;
        end
    endtask

    task automatic test_colour_bars();
        int xs[4] = '{0, 80, 639, 700};
        logic [23:0] req[4];
        bit seen[4] = '{0, 0, 0, 0};
        int rx;
        exp_t e;
`ifdef VIDEO_TPG_EN
        req = '{24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};
`else
        req = '{24'h0, 24'h0, 24'h0, 24'h0};
`endif
        rx = $urandom_range(0, 639);
        for (int c = 0; c < HT_D + 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (!seen[k] && x_d == 10'(xs[k])) begin
                    seen[k] = 1'b1;
                    n_checks++;
                    if (rgb_d !== req[k]) begin
                        n_fail++; $display("FAIL bar_x%0d got=%h want=%h", xs[k], rgb_d, req[k]);
                    end
                end
            end
            if (x_d == 10'(rx)) begin
                e = model(pos_d, inr_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
                n_checks++;
                if (rgb_d !== e.rgb) begin
                    n_fail++; $display("FAIL bar_rand x=%0d got=%h want=%h", rx, rgb_d, e.rgb);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (!seen[k]) begin n_fail++; $display("FAIL bar_seen x=%0d got=0 want=1", xs[k]); end
        end
    endtask

    task automatic test_frame_timing();
        exp_t e;
        logic [43:0] got, want;
        int last_fs, vs_beg;
        bit prev_vs;
        last_fs = -1; vs_beg = 0; prev_vs = 1;
        rst_m = 1'b0;
        for (int c = 0; c < 2 * FR_M + 20; c++) begin
            @(negedge clk);
            e = model(pos_m, inr_m, 640, 16, 96, 48, MV_A, MV_F, MV_S, MV_B, 1'b0, 1'b0);
            got  = {hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m};
            want = {e.hs, e.vs, e.de, e.ls, e.fs, 10'(e.x), 5'(e.y), e.rgb};
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL frame_vec cyc=%0d got=%h want=%h", c, got, want);
            end
            n_checks++;
            if (de_m && y_m >= 5'(MV_A)) begin
                n_fail++; $display("FAIL de_vblank y=%0d got=1 want=0", y_m);
            end
            if (fs_m) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (c - last_fs != FR_M) begin
                        n_fail++; $display("FAIL fs_period got=%0d want=%0d", c - last_fs, FR_M);
                    end
                end
                last_fs = c;
            end
            if (prev_vs && !vs_m) begin
                vs_beg = c;
                n_checks++;
                if ({x_m, y_m} !== {10'd0, 5'(MV_A + MV_F)}) begin
                    n_fail++; $display("FAIL vs_start got=%0d,%0d want=0,%0d", x_m, y_m, MV_A + MV_F);
                end
            end
            if (!prev_vs && vs_m) begin
                n_checks++;
                if (c - vs_beg != MV_S * 800) begin
                    n_fail++; $display("FAIL vs_len got=%0d want=%0d", c - vs_beg, MV_S * 800);
                end
            end
            prev_vs = vs_m;
        end
        n_checks++;
        if (last_fs < 0) begin n_fail++; $display("FAIL fs_seen got=0 want=1"); end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [43:0] got, want;
        bit hit;
        int wait_n, hold_n;
        hit = 0;
        for (int c = 0; c < FR_M + 10 && !hit; c++) begin
            @(negedge clk);
            if (x_m == 10'd300 && y_m == 5'd5) hit = 1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL mid_wait got=timeout want=x300y5"); end
        rst_m = 1'b1;
        @(negedge clk);
        rst_m = 1'b0;
        n_checks++;
        if ({hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m} !== {5'b11000, 10'd0, 5'd0, 24'd0}) begin
            n_fail++;
            $display("FAIL mid_rst got=%h want=%h", {hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m},
                     {5'b11000, 10'd0, 5'd0, 24'd0});
        end
        @(negedge clk);
        n_checks++;
        if ({de_m, ls_m, fs_m, x_m, y_m} !== {3'b111, 10'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL mid_restart got=%h want=%h", {de_m, ls_m, fs_m, x_m, y_m}, {3'b111, 10'd0, 5'd0});
        end
        for (int r = 0; r < 4; r++) begin
            wait_n = $urandom_range(1, 3000);
            hold_n = $urandom_range(1, 3);
            for (int c = 0; c < wait_n + hold_n + 3; c++) begin
                rst_m = (c >= wait_n && c < wait_n + hold_n);
                @(negedge clk);
                e = model(pos_m, inr_m, 640, 16, 96, 48, MV_A, MV_F, MV_S, MV_B, 1'b0, 1'b0);
                got  = {hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m, rgb_m};
                want = {e.hs, e.vs, e.de, e.ls, e.fs, 10'(e.x), 5'(e.y), e.rgb};
                n_checks++;
                if (got !== want) begin
                    n_fail++; $display("FAIL rand_rst r=%0d cyc=%0d got=%h want=%h", r, c, got, want);
                end
            end
        end
        rst_m = 1'b0;
    endtask

    task automatic test_small_mode();
        exp_t e;
        logic [35:0] got, want;
        int last_fs, pulse_at;
        logic [3:0] px;
        logic [2:0] py;
        last_fs = -1; px = 4'd0; py = 3'd0;
        pulse_at = $urandom_range(3 * FR_S + 5, 3 * FR_S + 60);
        rst_s = 1'b0;
        for (int c = 0; c < 5 * FR_S; c++) begin
            rst_s = (c == pulse_at);
            @(negedge clk);
            e = model(pos_s, inr_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
            got  = {hs_s, vs_s, de_s, ls_s, fs_s, x_s, y_s, rgb_s};
            want = {e.hs, e.vs, e.de, e.ls, e.fs, 4'(e.x), 3'(e.y), e.rgb};
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL small_vec cyc=%0d got=%h want=%h", c, got, want);
            end
            if (c < pulse_at) begin
                if (px == 4'd13) begin
                    n_checks++;
                    if (x_s !== 4'd0) begin n_fail++; $display("FAIL small_xwrap got=%0d want=0", x_s); end
                    if (py == 3'd6) begin
                        n_checks++;
                        if (y_s !== 3'd0) begin n_fail++; $display("FAIL small_ywrap got=%0d want=0", y_s); end
                    end
                end
                if (fs_s) begin
                    if (last_fs >= 0) begin
                        n_checks++;
                        if (c - last_fs != FR_S) begin
                            n_fail++; $display("FAIL small_period got=%0d want=%0d", c - last_fs, FR_S);
                        end
                    end
                    last_fs = c;
                end
            end
            px = x_s; py = y_s;
        end
        rst_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_colour_bars();
        test_frame_timing();
        test_mid_reset();
        test_small_mode();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
